caliptra_ss_tb_cmd_sequencer: RTL

Testbench-side producer of the `tb_service_cmd_valid` / `tb_service_cmd` service-command interface consumed by the fuse-ctrl/LCC service block and the other TB service blocks.

- It snoops firmware writes to a dedicated testbench mailbox address on the MCU LSU write path.
- Accepted command bytes are queued.
- Each queued command is replayed as a single-cycle valid pulse.
- Programmable delay and hold-off spacing keep back-to-back commands, such as a fuse-ctrl/LCC reset followed by a force, from overlapping.

---
 rtl/caliptra_ss_tb_cmd_seq_pkg.sv | 35 +++
 rtl/caliptra_ss_tb_cmd_fifo.sv | 59 +++++
 rtl/caliptra_ss_tb_cmd_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/caliptra_ss_tb_cmd_seq_pkg.sv
// Shared types and constants for the TB command sequencer.
// CPTRA_SS_TB_CMD_DELAY_EN adds the per-command delay field and the WAIT state.
package caliptra_ss_tb_cmd_seq_pkg;

  localparam logic [31:0] CMD_ADDR_DEFAULT = 32'h2600_0000;

  // TB service command list shared with the fuse-ctrl/LCC service block
  localparam logic [7:0] CMD_FC_LCC_RESET         = 8'hF0;
  localparam logic [7:0] CMD_FC_LCC_FORCE         = 8'hF1;
  localparam logic [7:0] CMD_FC_LCC_FAULT_DIGEST  = 8'hF2;
  localparam logic [7:0] CMD_FC_LCC_CORRUPT_OTP   = 8'hF3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
`ifdef CPTRA_SS_TB_CMD_DELAY_EN
    ,
    ST_WAIT  = 2'd3
`endif
  } seq_state_e;

  typedef struct packed {
`ifdef CPTRA_SS_TB_CMD_DELAY_EN
    logic [7:0] delay;
`endif
    logic [7:0] cmd;
  } cmd_entry_t;

  // Bits needed for a down-counter that must hold max_val
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/caliptra_ss_tb_cmd_fifo.sv
// Synchronous FIFO for queued TB commands; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module caliptra_ss_tb_cmd_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             cptra_rst_b,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/caliptra_ss_tb_cmd_sequencer.sv
// Snoops FW writes to the TB mailbox and replays each command as a spaced
// single-cycle pulse. CPTRA_SS_TB_CMD_DELAY_EN enables per-command delays.
module caliptra_ss_tb_cmd_sequencer
  import caliptra_ss_tb_cmd_seq_pkg::*;
#(
  parameter logic [31:0] CMD_ADDR   = CMD_ADDR_DEFAULT,
  parameter int          FIFO_DEPTH = 8,
  parameter int          MIN_GAP    = 2,
  parameter int          RESET_HOLD = 12
) (
  input  logic        clk,
  input  logic        cptra_rst_b,
  input  logic        wr_valid,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic        tb_service_cmd_valid,
  output logic [7:0]  tb_service_cmd,
  output logic        cmd_busy,
  output logic [7:0]  cmd_drop_cnt
);

  localparam int GAP_MAX = (MIN_GAP > RESET_HOLD) ? MIN_GAP : RESET_HOLD;
  localparam int GAP_W   = cnt_width(GAP_MAX);
  localparam int ENTRY_W = $bits(cmd_entry_t);
  localparam logic [GAP_W-1:0] GAP_NORMAL = GAP_W'(MIN_GAP);
  localparam logic [GAP_W-1:0] GAP_RESET  = GAP_W'(RESET_HOLD);

  seq_state_e       state;
  cmd_entry_t       push_entry;
  cmd_entry_t       head_entry;
  cmd_entry_t       cur_entry;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic             push;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [GAP_W-1:0] gap_cnt;
`ifdef CPTRA_SS_TB_CMD_DELAY_EN
  logic [7:0]       dly_cnt;
`endif
  logic             unused_wr_bits;

  assign unused_wr_bits = ^{wr_data[31:8], wr_strb[3:1]};

  // Zero is the no-op command and never occupies a queue slot
  always_comb begin
    push_entry     = '0;
    push_entry.cmd = wr_data[7:0];
`ifdef CPTRA_SS_TB_CMD_DELAY_EN
    push_entry.delay = wr_strb[1] ? wr_data[15:8] : 8'h00;
`endif
    push = wr_valid && (wr_addr == CMD_ADDR) && wr_strb[0] && (wr_data[7:0] != 8'h00);
  end

  assign head_entry = cmd_entry_t'(fifo_rdata);
  assign pop        = (state == ST_IDLE) && !fifo_empty;
  assign drop       = push && fifo_full && !pop;

  caliptra_ss_tb_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk         (clk),
    .cptra_rst_b (cptra_rst_b),
    .push        (push),
    .push_data   (push_entry),
    .pop         (pop),
    .pop_data    (fifo_rdata),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  always_ff @(posedge clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      cmd_drop_cnt <= 8'h00;
    end else if (drop && (cmd_drop_cnt != 8'hFF)) begin
      cmd_drop_cnt <= cmd_drop_cnt + 8'h01;
    end
  end

  // Sequencing FSM; all outputs are registered here
  always_ff @(posedge clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      state                <= ST_IDLE;
      cur_entry            <= '0;
      gap_cnt              <= '0;
`ifdef CPTRA_SS_TB_CMD_DELAY_EN
      dly_cnt              <= 8'h00;
`endif
      tb_service_cmd_valid <= 1'b0;
      tb_service_cmd       <= 8'h00;
      cmd_busy             <= 1'b0;
    end else begin
      tb_service_cmd_valid <= 1'b0;
      cmd_busy             <= !fifo_empty || (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur_entry <= head_entry;
`ifdef CPTRA_SS_TB_CMD_DELAY_EN
            if (head_entry.delay == 8'h00) begin
              state <= ST_ISSUE;
            end else begin
              dly_cnt <= head_entry.delay - 8'h01;
              state   <= ST_WAIT;
            end
`else
            state <= ST_ISSUE;
`endif
          end
        end
`ifdef CPTRA_SS_TB_CMD_DELAY_EN
        ST_WAIT: begin
          if (dly_cnt == 8'h00) begin
            state <= ST_ISSUE;
          end else begin
            dly_cnt <= dly_cnt - 8'h01;
          end
        end
`endif
        ST_ISSUE: begin
          tb_service_cmd_valid <= 1'b1;
          tb_service_cmd       <= cur_entry.cmd;
          gap_cnt <= (cur_entry.cmd == CMD_FC_LCC_RESET) ? GAP_RESET : GAP_NORMAL;
          state   <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
